// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweeper and its bench model.
package tt_sweep_pkg;

    localparam int unsigned TT_WIDTH  = 8;
    localparam int unsigned VEC_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_t;

    // Vector idx={in1,in2,in3} lands in bit (7-idx) of the truth-table word.
    function automatic logic [VEC_WIDTH-1:0] tt_bit_index(input logic [VEC_WIDTH-1:0] idx);
        return VEC_WIDTH'(3'd7 - idx);
    endfunction

endpackage

// File: rtl/sync_majority3.sv
// Two-flop synchroniser followed by a 3-sample history and a registered majority vote.
module sync_majority3 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [1:0] sync;
    logic [2:0] hist;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= 2'b00;
            hist <= 3'b000;
            q    <= 1'b0;
        end else begin
            sync <= {sync[0], d};
            hist <= {hist[1:0], sync[1]};
            // A lone glitch occupies at most one history slot, so it never wins the vote.
            q    <= (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives a 3-input cell through all 8 input vectors, captures its filtered output
// after each settle window and compares the assembled truth table to EXPECTED.
module truth_table_sweeper
    import tt_sweep_pkg::*;
#(
    parameter int unsigned         SETTLE_CYCLES = 16,
    parameter logic [TT_WIDTH-1:0] EXPECTED      = 8'hDC
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                cell_out,
    output logic                in1,
    output logic                in2,
    output logic                in3,
    output logic                busy,
    output logic                done,
    output logic [TT_WIDTH-1:0] table_word,
    output logic                match,
    output logic [TT_WIDTH-1:0] mismatch_mask
);

    localparam logic [7:0] LAST_COUNT = 8'(SETTLE_CYCLES - 1);

    // The majority window needs three samples inside a single hold.
    if (SETTLE_CYCLES < 3 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("truth_table_sweeper: SETTLE_CYCLES must be within 3..255");
    end

    state_t                state;
    logic [7:0]            count;
    logic [VEC_WIDTH-1:0]  idx;
    logic                  sample;
    logic [TT_WIDTH-1:0]   word_next;

    sync_majority3 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (cell_out),
        .q     (sample)
    );

    // Table word with the current vector's sampled bit folded in.
    always_comb begin
        word_next                    = table_word;
        word_next[tt_bit_index(idx)] = sample;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            count         <= 8'd0;
            idx           <= '0;
            {in1, in2, in3} <= 3'b000;
            busy          <= 1'b0;
            done          <= 1'b0;
            table_word    <= '0;
            match         <= 1'b0;
            mismatch_mask <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state           <= HOLD;
                        count           <= 8'd0;
                        idx             <= '0;
                        {in1, in2, in3} <= 3'b000;
                        busy            <= 1'b1;
                        table_word      <= '0;
                        match           <= 1'b0;
                        mismatch_mask   <= '0;
                    end
                end
                HOLD: begin
                    if (count == LAST_COUNT) begin
                        count      <= 8'd0;
                        table_word <= word_next;
                        if (idx == 3'd7) begin
                            state           <= DONE;
                            done            <= 1'b1;
                            busy            <= 1'b0;
                            {in1, in2, in3} <= 3'b000;
                            match           <= (word_next == EXPECTED);
                            mismatch_mask   <= word_next ^ EXPECTED;
                        end else begin
                            idx             <= idx + 3'd1;
                            {in1, in2, in3} <= idx + 3'd1;
                        end
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench: behavioural cell model with configurable code/delay/glitch,
// table-driven and random sweeps, plus reset and back-to-back corner sequences.
module tb_truth_table_sweeper;
    import tt_sweep_pkg::*;

    localparam int unsigned S      = 16;
    localparam logic [7:0]  EXP    = 8'hDC;
    localparam int          SWEEP  = 8 * S + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       cell_out;
    logic       in1, in2, in3, busy, done, match;
    logic [7:0] table_word, mismatch_mask;

    // Cell model state
    logic [7:0]  cell_code;
    int unsigned cell_delay;
    logic        glitch;
    logic [7:0]  hist;
    logic        ideal;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        logic [7:0]  code;
        int unsigned delay;
        int          glitch_cyc;
        logic [7:0]  exp_word;
    } vec_t;

    vec_t tbl[5];

    truth_table_sweeper #(.SETTLE_CYCLES(S), .EXPECTED(EXP)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .cell_out      (cell_out),
        .in1           (in1),
        .in2           (in2),
        .in3           (in3),
        .busy          (busy),
        .done          (done),
        .table_word    (table_word),
        .match         (match),
        .mismatch_mask (mismatch_mask)
    );

    always #5 clk = ~clk;

    always_comb ideal = cell_code[tt_bit_index({in1, in2, in3})];
    always @(posedge clk) hist <= {hist[6:0], ideal};
    always_comb cell_out = glitch | ((cell_delay == 0) ? ideal : hist[3'(cell_delay - 1)]);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_in"},   32'({in1, in2, in3}), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_word"}, 32'(table_word), 32'd0);
        chk({name, "_match"}, 32'(match), 32'd0);
        chk({name, "_mask"}, 32'(mismatch_mask), 32'd0);
    endtask

    // One full sweep from a start pulse; checks vector timing, done latency and results.
    task automatic do_sweep(input string name, input logic [7:0] code, input int unsigned dly,
                            input int glitch_cyc, input logic [7:0] exp_word);
        int cyc;
        int vec_err;
        bit seen;
        cell_code  = code;
        cell_delay = dly;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 1; vec_err = 0; seen = 0;
        while (cyc <= SWEEP + 8) begin
            glitch = (cyc == glitch_cyc);
            if (done) begin seen = 1; break; end
            if (cyc <= 8 * S && ({in1, in2, in3} != 3'((cyc - 1) / S) || busy !== 1'b1))
                vec_err++;
            @(negedge clk); cyc++;
        end
        glitch = 1'b0;
        chk({name, "_done_seen"}, 32'(seen), 32'd1);
        chk({name, "_done_cycle"}, 32'(cyc), 32'(SWEEP));
        chk({name, "_vec_seq_errs"}, 32'(vec_err), 32'd0);
        chk({name, "_word"}, 32'(table_word), 32'(exp_word));
        chk({name, "_match"}, 32'(match), 32'(exp_word == EXP));
        chk({name, "_mask"}, 32'(mismatch_mask), 32'(exp_word ^ EXP));
        chk({name, "_busy_end"}, 32'(busy), 32'd0);
        chk({name, "_in_end"}, 32'({in1, in2, in3}), 32'd0);
        @(negedge clk);
        chk({name, "_done_pulse"}, 32'(done), 32'd0);
        chk({name, "_word_held"}, 32'(table_word), 32'(exp_word));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        int cyc;
        logic [7:0] rc;

        tbl[0] = '{"ideal_dc",     8'hDC, 0, 0,  8'hDC};
        tbl[1] = '{"delay5_dc",    8'hDC, 5, 0,  8'hDC};
        tbl[2] = '{"stuck0",       8'h00, 0, 0,  8'h00};
        tbl[3] = '{"glitch_last2", 8'hDC, 0, 48, 8'hDC};
        tbl[4] = '{"glitch_win2",  8'hDC, 0, 44, 8'hDC};

        cell_code = EXP; cell_delay = 0; glitch = 1'b0; hist = '0;
        start = 1'b0; reset = 1'b1;
        #1;
        chk_zero("reset_async");
        // start asserted together with reset must be ignored
        @(negedge clk); start = 1'b1;
        @(negedge clk);
        chk_zero("reset_with_start");
        start = 1'b0;
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        chk_zero("idle_after_reset");

        foreach (tbl[i])
            do_sweep(tbl[i].name, tbl[i].code, tbl[i].delay, tbl[i].glitch_cyc, tbl[i].exp_word);

        // Random cell functions and delays: observed table must equal the cell's own code.
        for (int k = 0; k < 6; k++) begin
            rc = 8'($urandom);
            if (k == 0) rc = EXP;
            do_sweep($sformatf("rand%0d", k), rc, $urandom_range(0, 5), 0, rc);
        end

        // Start during a sweep is ignored; reset at vector 3 aborts; fresh sweep completes.
        cell_code = EXP; cell_delay = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c < 56; c++) begin
            start = (c == 40);
            @(negedge clk);
        end
        start = 1'b0;
        chk("ignored_start_busy", 32'(busy), 32'd1);
        chk("ignored_start_vec", 32'({in1, in2, in3}), 32'd3);
        chk("partial_word", 32'(table_word), 32'hC0);
        reset = 1'b1;
        #1;
        chk_zero("reset_midsweep");
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        chk_zero("after_abort");
        do_sweep("after_reset", EXP, 0, 0, EXP);

        // start held high: next sweep begins on the cycle after done
        cell_code = 8'h5A;
        @(negedge clk); start = 1'b1;
        seen = 0;
        for (int c = 0; c < SWEEP + 8; c++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
        end
        chk("b2b_first_done", 32'(seen), 32'd1);
        chk("b2b_first_word", 32'(table_word), 32'h5A);
        @(negedge clk);
        chk("b2b_restart_busy", 32'(busy), 32'd1);
        chk("b2b_restart_done", 32'(done), 32'd0);
        chk("b2b_restart_word", 32'(table_word), 32'd0);
        start = 1'b0;
        cyc = 1; seen = 0;
        while (cyc < SWEEP + 8) begin
            @(negedge clk); cyc++;
            if (done) begin seen = 1; break; end
        end
        chk("b2b_second_done", 32'(seen), 32'd1);
        chk("b2b_second_cycle", 32'(cyc), 32'(SWEEP));
        chk("b2b_second_mask", 32'(mismatch_mask), 32'(8'h5A ^ EXP));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
